reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Top-level reset controller. It consumes the raw system clock and the asynchronous active-high reset from the board or bench, and synchronizes reset deassertion. It stretches the reset, then releases NUM_DOMAINS downstream reset lines one at a time in a fixed order, and signals Ready once all domains are running. A synchronous soft-reset request re-runs the sequence without the external reset and is counted for debug.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on reset deassertion; ≥2
- STRETCH_CYCLES, 16, cycles all domains stay in reset after sync; ≥1
- NUM_DOMAINS, 3, number of sequenced reset outputs; ≥1
- STAGE_GAP, 4, cycles between consecutive domain releases; ≥1

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-high reset
- SoftReq  in  1  synchronous soft-reset request, sampled only in RUN
- RstOut  out  NUM_DOMAINS  active-high per-domain resets; bit 0 released first
- Ready  out  1  high only in RUN
- State  out  2  FSM state: SYNC=0, STRETCH=1, RELEASE=2, RUN=3
- ResetCount  out  8  saturating count of accepted soft resets

## Operation
- Reset is one clock domain. It is asynchronous and active-high.
- While Reset=1, all of the following hold immediately, without waiting for a clock edge:
  - synchronizer chain all ones
  - RstOut all ones
  - Ready=0, State=SYNC
  - internal counter=0, domain index=0, ResetCount=0
- Synchronizer: SYNC_STAGES flops, asynchronously set by Reset, shifting in 0 each edge. The synced reset is the last flop.
- SYNC: when the synced reset is 0 at an edge, go to STRETCH with counter=0.
- STRETCH: counter increments each edge. At the edge where counter==STRETCH_CYCLES-1:
  - clear RstOut[0]
  - if NUM_DOMAINS==1, go to RUN with Ready=1
  - otherwise go to RELEASE with index=1 and counter=0
- RELEASE: counter increments each edge. At the edge where counter==STAGE_GAP-1:
  - clear RstOut[index] and reset counter
  - if index==NUM_DOMAINS-1, go to RUN with Ready=1 on that same edge
  - otherwise increment index
- RUN: holds indefinitely. If SoftReq=1 at an edge:
  - RstOut goes all ones and Ready=0
  - ResetCount increments, saturating at 255
  - go to STRETCH with counter=0; the synchronizer is bypassed
- SoftReq is ignored (not counted) in SYNC, STRETCH and RELEASE.
- RstOut bits are only ever cleared in ascending index order. Bits never deassert out of order or glitch.
- Reset asserted in any state aborts the sequence immediately (full async reset). On deassertion, the sequence restarts from SYNC.

## Timing
- Edge 1 is the first rising edge after Reset falls.
- Synced reset is low after edge SYNC_STAGES. State=STRETCH from edge SYNC_STAGES+1.
- Domain releases:
  - RstOut[0] falls at edge E0 = SYNC_STAGES+1+STRETCH_CYCLES (defaults: 19)
  - RstOut[i] falls at edge E0 + i·STAGE_GAP (defaults: 23, 27)
  - Ready rises at edge E0 + (NUM_DOMAINS-1)·STAGE_GAP (defaults: 27)
- Soft reset sampled at edge e: RstOut all ones and Ready=0 at edge e. RstOut[0] falls at e+STRETCH_CYCLES, remaining domains follow at STAGE_GAP spacing.
- A Reset pulse shorter than one clock period still fully resets. All outputs are registered, with no combinational path from inputs.

## Test plan
- Power-up, defaults, 10 ns clock; Reset high 10 ns then low -> RstOut=3'b111 until edge 19; then 3'b110 at 19, 3'b100 at 23, 3'b000 at 27; Ready=1 and State=3 at 27.
- In RUN, one-cycle SoftReq at edge e -> RstOut=3'b111, Ready=0, State=1, ResetCount=1 at e; RstOut[0] falls at e+16; Ready=1 at e+24.
- SoftReq held high during STRETCH and RELEASE -> no effect and ResetCount unchanged; the sequence timing matches power-up exactly.
- Reset reasserted mid-RELEASE (after RstOut=3'b110) -> RstOut=3'b111, Ready=0, State=0, ResetCount=0 immediately without a clock edge; release restarts 19 edges after deassertion.
- 300 accepted soft resets -> ResetCount saturates at 255 and does not wrap.
- Parameter sweep with NUM_DOMAINS=1, STRETCH_CYCLES=1, SYNC_STAGES=3 -> RstOut[0] falls and Ready rises together at edge 5.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes reset release, stretches it, then releases
// per-domain resets in ascending order; soft requests in RUN replay the sequence.
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int NUM_DOMAINS    = 3,
    parameter int STAGE_GAP      = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   SoftReq,
    output logic [NUM_DOMAINS-1:0] RstOut,
    output logic                   Ready,
    output logic [1:0]             State,
    output logic [7:0]             ResetCount
);
    localparam int MAXC = STRETCH_CYCLES > STAGE_GAP ? STRETCH_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [1:0] {SYNC = 2'd0, STRETCH = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic [7:0]             count_q, count_d;
    logic                   stretch_done, gap_done, last_dom;

    assign sync_d       = {sync_q[SYNC_STAGES-2:0], 1'b0};
    assign stretch_done = cnt_q == CW'(STRETCH_CYCLES - 1);
    assign gap_done     = cnt_q == CW'(STAGE_GAP - 1);
    assign last_dom     = idx_q == IW'(NUM_DOMAINS - 1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q    <= '1;
            state_q   <= SYNC;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        case (state_q)
            SYNC: begin
                cnt_d   = '0;
                state_d = sync_q[SYNC_STAGES-1] ? SYNC : STRETCH;
            end
            STRETCH: if (stretch_done) begin
                cnt_d   = '0;
                idx_d   = IW'(1);
                state_d = NUM_DOMAINS == 1 ? RUN : RELEASE;
            end
            RELEASE: if (gap_done) begin
                cnt_d   = '0;
                idx_d   = last_dom ? idx_q : idx_q + IW'(1);
                state_d = last_dom ? RUN : RELEASE;
            end
            default: begin
                cnt_d   = '0;
                state_d = SoftReq ? STRETCH : RUN;
            end
        endcase
    end

    // Bits only ever clear one at a time at idx_q, so release order is ascending by construction.
    always_comb begin
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        count_d   = count_q;
        case (state_q)
            STRETCH: begin
                rst_out_d[0] = rst_out_q[0] & ~stretch_done;
                ready_d      = stretch_done && NUM_DOMAINS == 1;
            end
            RELEASE: begin
                rst_out_d = gap_done ? rst_out_q & ~(NUM_DOMAINS'(1) << idx_q) : rst_out_q;
                ready_d   = gap_done && last_dom;
            end
            RUN: begin
                rst_out_d = SoftReq ? '1 : rst_out_q;
                ready_d   = !SoftReq;
                count_d   = count_q + 8'(SoftReq && count_q != 8'hff);
            end
            default: ;
        endcase
    end

    assign RstOut     = rst_out_q;
    assign Ready      = ready_q;
    assign State      = state_q;
    assign ResetCount = count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: checks the reset sequencer against a timeline model that
// derives every output from the number of edges since the sequence started.
module tb_reset_sequencer;
    localparam int S  = 2;
    localparam int ST = 16;
    localparam int ND = 3;
    localparam int G  = 4;
    localparam int E0 = S + 1 + ST;
    localparam int EL = E0 + (ND - 1) * G;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       SoftReq = 1'b0;
    logic [2:0] RstOut;
    logic       Ready;
    logic [1:0] State;
    logic [7:0] ResetCount;
    logic [0:0] rst2;
    logic       ready2;
    logic [1:0] state2;
    logic [7:0] count2;

    int errors = 0;
    int checks = 0;
    int p  = 0;
    int p2 = 0;
    int cnt = 0;

    reset_sequencer u_dut (
        .Clk(Clk), .Reset(Reset), .SoftReq(SoftReq),
        .RstOut(RstOut), .Ready(Ready), .State(State), .ResetCount(ResetCount)
    );

    reset_sequencer #(.SYNC_STAGES(3), .STRETCH_CYCLES(1), .NUM_DOMAINS(1), .STAGE_GAP(4)) u_small (
        .Clk(Clk), .Reset(Reset), .SoftReq(1'b0),
        .RstOut(rst2), .Ready(ready2), .State(state2), .ResetCount(count2)
    );

    always #5 Clk = ~Clk;

    // p counts edges since the sequence began; a soft reset is equivalent to entering STRETCH at p=s+1.
    function automatic logic [1:0] m_state(int pp, int s, int st, int nd, int g);
        int e0 = s + 1 + st;
        int el = e0 + (nd - 1) * g;
        if (pp <= s) return 2'd0;
        if (pp < e0) return 2'd1;
        if (pp < el) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [7:0] m_rst(int pp, int s, int st, int nd, int g);
        logic [7:0] r = '0;
        for (int i = 0; i < nd; i++) r[i] = pp < s + 1 + st + i * g;
        return r;
    endfunction

    function automatic logic m_ready(int pp, int s, int st, int nd, int g);
        return pp >= s + 1 + st + (nd - 1) * g;
    endfunction

    task automatic step();
        @(posedge Clk);
        if (SoftReq && p >= EL) begin
            p = S + 1;
            cnt = cnt == 255 ? 255 : cnt + 1;
        end else if (p < 1000000) p++;
        if (p2 < 1000000) p2++;
        #1;
    endtask

    task automatic do_reset();
        SoftReq = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        p = 0; p2 = 0; cnt = 0;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b1;
        #1;
        checks += 5;
        if (RstOut !== 3'b111) begin errors++; $display("FAIL reset_rst got=%b exp=111", RstOut); end
        if (Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", Ready); end
        if (State !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", State); end
        if (ResetCount !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ResetCount); end
        if (rst2 !== 1'b1) begin errors++; $display("FAIL reset_small_rst got=%b exp=1", rst2); end
        #8 Reset = 1'b0;
        p = 0; p2 = 0; cnt = 0;
    endtask

    task automatic test_power_up();
        for (int i = 0; i < 32; i++) begin
            step();
            checks += 3;
            if (RstOut !== m_rst(p, S, ST, ND, G)[2:0]) begin errors++; $display("FAIL pwr_rst edge=%0d got=%b exp=%b", p, RstOut, m_rst(p, S, ST, ND, G)[2:0]); end
            if (Ready !== m_ready(p, S, ST, ND, G)) begin errors++; $display("FAIL pwr_ready edge=%0d got=%b exp=%b", p, Ready, m_ready(p, S, ST, ND, G)); end
            if (State !== m_state(p, S, ST, ND, G)) begin errors++; $display("FAIL pwr_state edge=%0d got=%0d exp=%0d", p, State, m_state(p, S, ST, ND, G)); end
        end
    endtask

    task automatic test_soft_reset();
        SoftReq = 1'b1;
        step();
        SoftReq = 1'b0;
        checks += 4;
        if (RstOut !== 3'b111) begin errors++; $display("FAIL soft_rst got=%b exp=111", RstOut); end
        if (Ready !== 1'b0) begin errors++; $display("FAIL soft_ready got=%b exp=0", Ready); end
        if (State !== 2'd1) begin errors++; $display("FAIL soft_state got=%0d exp=1", State); end
        if (ResetCount !== 8'd1) begin errors++; $display("FAIL soft_count got=%0d exp=1", ResetCount); end
        for (int i = 0; i < 28; i++) begin
            step();
            checks += 4;
            if (RstOut !== m_rst(p, S, ST, ND, G)[2:0]) begin errors++; $display("FAIL soft_seq_rst p=%0d got=%b exp=%b", p, RstOut, m_rst(p, S, ST, ND, G)[2:0]); end
            if (Ready !== m_ready(p, S, ST, ND, G)) begin errors++; $display("FAIL soft_seq_ready p=%0d got=%b exp=%b", p, Ready, m_ready(p, S, ST, ND, G)); end
            if (State !== m_state(p, S, ST, ND, G)) begin errors++; $display("FAIL soft_seq_state p=%0d got=%0d exp=%0d", p, State, m_state(p, S, ST, ND, G)); end
            if (ResetCount !== 8'(cnt)) begin errors++; $display("FAIL soft_seq_count got=%0d exp=%0d", ResetCount, cnt); end
        end
    endtask

    task automatic test_soft_ignored();
        do_reset();
        SoftReq = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            if (p >= EL) SoftReq = 1'b0;
            checks += 4;
            if (RstOut !== m_rst(p, S, ST, ND, G)[2:0]) begin errors++; $display("FAIL ign_rst edge=%0d got=%b exp=%b", p, RstOut, m_rst(p, S, ST, ND, G)[2:0]); end
            if (Ready !== m_ready(p, S, ST, ND, G)) begin errors++; $display("FAIL ign_ready edge=%0d got=%b exp=%b", p, Ready, m_ready(p, S, ST, ND, G)); end
            if (State !== m_state(p, S, ST, ND, G)) begin errors++; $display("FAIL ign_state edge=%0d got=%0d exp=%0d", p, State, m_state(p, S, ST, ND, G)); end
            if (ResetCount !== 8'd0) begin errors++; $display("FAIL ign_count got=%0d exp=0", ResetCount); end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 10000 && cnt < 300; i++) begin
            SoftReq = p >= EL;
            step();
            if (SoftReq && p == S + 1 && cnt == 255) cnt = cnt;
            checks++;
            if (ResetCount !== 8'(cnt)) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", ResetCount, cnt); end
            if (ResetCount == 8'd255 && i > 9000) break;
        end
        SoftReq = 1'b0;
        for (int k = 0; k < 60 && cnt == 255; k++) begin
            SoftReq = p >= EL;
            step();
        end
        SoftReq = 1'b0;
        checks++;
        if (ResetCount !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d exp=255", ResetCount); end
        while (p < EL) step();
    endtask

    task automatic test_abort();
        SoftReq = 1'b1;
        step();
        SoftReq = 1'b0;
        while (p < E0 + 1) step();
        checks++;
        if (RstOut !== 3'b110) begin errors++; $display("FAIL abort_pre got=%b exp=110", RstOut); end
        #2 Reset = 1'b1;
        #1;
        checks += 4;
        if (RstOut !== 3'b111) begin errors++; $display("FAIL abort_rst got=%b exp=111", RstOut); end
        if (Ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", Ready); end
        if (State !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", State); end
        if (ResetCount !== 8'd0) begin errors++; $display("FAIL abort_count got=%0d exp=0", ResetCount); end
        Reset = 1'b0;
        p = 0; p2 = 0; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks += 2;
            if (RstOut !== m_rst(p, S, ST, ND, G)[2:0]) begin errors++; $display("FAIL abort_seq_rst edge=%0d got=%b exp=%b", p, RstOut, m_rst(p, S, ST, ND, G)[2:0]); end
            if (State !== m_state(p, S, ST, ND, G)) begin errors++; $display("FAIL abort_seq_state edge=%0d got=%0d exp=%0d", p, State, m_state(p, S, ST, ND, G)); end
        end
    endtask

    task automatic test_small_param();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            checks += 3;
            if (rst2 !== m_rst(p2, 3, 1, 1, 4)[0]) begin errors++; $display("FAIL small_rst edge=%0d got=%b exp=%b", p2, rst2, m_rst(p2, 3, 1, 1, 4)[0]); end
            if (ready2 !== m_ready(p2, 3, 1, 1, 4)) begin errors++; $display("FAIL small_ready edge=%0d got=%b exp=%b", p2, ready2, m_ready(p2, 3, 1, 1, 4)); end
            if (state2 !== m_state(p2, 3, 1, 1, 4)) begin errors++; $display("FAIL small_state edge=%0d got=%0d exp=%0d", p2, state2, m_state(p2, 3, 1, 1, 4)); end
            if (p2 == 5) begin
                checks++;
                if ({rst2, ready2} !== 2'b01) begin errors++; $display("FAIL small_edge5 got=%b%b exp=01", rst2, ready2); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            SoftReq = $urandom_range(0, 9) == 0;
            step();
            checks += 4;
            if (RstOut !== m_rst(p, S, ST, ND, G)[2:0]) begin errors++; $display("FAIL rnd_rst p=%0d got=%b exp=%b", p, RstOut, m_rst(p, S, ST, ND, G)[2:0]); end
            if (Ready !== m_ready(p, S, ST, ND, G)) begin errors++; $display("FAIL rnd_ready p=%0d got=%b exp=%b", p, Ready, m_ready(p, S, ST, ND, G)); end
            if (State !== m_state(p, S, ST, ND, G)) begin errors++; $display("FAIL rnd_state p=%0d got=%0d exp=%0d", p, State, m_state(p, S, ST, ND, G)); end
            if (ResetCount !== 8'(cnt)) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", ResetCount, cnt); end
            if ($urandom_range(0, 299) == 0) begin
                #2 Reset = 1'b1;
                #1 Reset = 1'b0;
                p = 0; p2 = 0; cnt = 0;
                checks++;
                if (RstOut !== 3'b111 || State !== 2'd0) begin errors++; $display("FAIL rnd_abort got=%b/%0d exp=111/0", RstOut, State); end
            end
        end
        SoftReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_soft_reset();
        test_soft_ignored();
        test_saturate();
        test_abort();
        test_small_param();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
